// File: rtl/mmio_button_bridge.sv
// -----------------------------------------------------------------------------
// mmio_button_bridge
//
// Memory-mapped bridge between a processor data port, four push buttons and a
// VGA output register.
//
//   * Buttons: each level input passes a 2-flop synchronizer and a
//     previous-value flop. A rising edge sets a sticky per-button flag that is
//     cleared when the processor reads that button's address. If a rise and a
//     read of the same button land in the same cycle, the read returns the old
//     flag and the flag ends set, so no event is lost.
//   * VGA output: a write to ADDR_OUT loads vga_data and raises vga_valid.
//     Writing while an unconsumed value is still pending overwrites it and
//     sets a sticky overflow bit. Reading the status word clears overflow.
//   * Read data: q_dmem is registered (1-cycle latency) and carries a button
//     flag, the status word, or q_ram, depending on the decoded read address.
//
// Status word: {26'b0, flag_d, flag_u, flag_r, flag_l, overflow, vga_valid}
//
// VGA handshake: vga_valid=1 means vga_data holds a value not yet taken.
// A transfer happens at a posedge where vga_valid and vga_ready are both 1.
// vga_data is stable while vga_valid=1 unless the processor writes ADDR_OUT.
// A write in the transfer cycle replaces the data and keeps vga_valid=1
// without counting as an overflow, since the old value was consumed.
//
// Ports:
//   clock        in   1  single clock, all state updates on posedge
//   reset        in   1  synchronous, active-high reset
//   wren         in   1  processor data-memory write enable
//   address_dmem in  32  processor data address (full 32-bit decode)
//   data         in  32  processor write data
//   q_ram        in  32  RAM read data, forwarded on non-bridge reads
//   btn_l/r/u/d  in   1  debounced button levels, asynchronous to clock
//   q_dmem       out 32  registered read data to the processor
//   vga_data     out 32  value presented to the VGA controller
//   vga_valid    out  1  vga_data holds an unconsumed value
//   vga_ready    in   1  VGA controller accepts vga_data
// -----------------------------------------------------------------------------
module mmio_button_bridge #(
    parameter logic [31:0] ADDR_OUT  = 32'd2000,
    parameter logic [31:0] ADDR_STAT = 32'd2004,
    parameter logic [31:0] ADDR_BTNL = 32'd3000,
    parameter logic [31:0] ADDR_BTNR = 32'd4000,
    parameter logic [31:0] ADDR_BTNU = 32'd5000,
    parameter logic [31:0] ADDR_BTND = 32'd6000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic [31:0] q_ram,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_u,
    input  logic        btn_d,
    output logic [31:0] q_dmem,
    output logic [31:0] vga_data,
    output logic        vga_valid,
    input  logic        vga_ready
);

    // Button vectors are ordered {d, u, r, l} so they drop straight into
    // the status word.
    logic [3:0]  btn_raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  prev;
    logic [3:0]  flag;
    logic [3:0]  rise;
    logic [3:0]  rd_btn;
    logic [3:0]  flag_next;

    logic        overflow;
    logic        rd_stat;
    logic        wr_out;
    logic        handshake;
    logic [31:0] status_word;
    logic [31:0] rd_data;

    assign btn_raw = {btn_d, btn_u, btn_r, btn_l};

    // Address decode
    assign rd_btn[0] = !wren && (address_dmem == ADDR_BTNL);
    assign rd_btn[1] = !wren && (address_dmem == ADDR_BTNR);
    assign rd_btn[2] = !wren && (address_dmem == ADDR_BTNU);
    assign rd_btn[3] = !wren && (address_dmem == ADDR_BTND);
    assign rd_stat   = !wren && (address_dmem == ADDR_STAT);
    assign wr_out    =  wren && (address_dmem == ADDR_OUT);

    assign handshake = vga_valid && vga_ready;

    // Edge detect happens after the second synchronizer stage.
    assign rise = sync2 & ~prev;

    // The rise is ORed in after the read-clear, so a same-cycle set wins.
    assign flag_next = (flag & ~rd_btn) | rise;

    assign status_word = {26'b0, flag, overflow, vga_valid};

    always_comb begin
        rd_data = q_ram;
        if (rd_stat) begin
            rd_data = status_word;
        end else if (rd_btn[0]) begin
            rd_data = {31'b0, flag[0]};
        end else if (rd_btn[1]) begin
            rd_data = {31'b0, flag[1]};
        end else if (rd_btn[2]) begin
            rd_data = {31'b0, flag[2]};
        end else if (rd_btn[3]) begin
            rd_data = {31'b0, flag[3]};
        end
    end

    // Button path and read data register
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 4'b0;
            sync2  <= 4'b0;
            prev   <= 4'b0;
            flag   <= 4'b0;
            q_dmem <= 32'b0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            prev   <= sync2;
            flag   <= flag_next;
            q_dmem <= rd_data;
        end
    end

    // VGA output register and overflow tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_data  <= 32'b0;
            vga_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_out) begin
                vga_data  <= data;
                vga_valid <= 1'b1;
                // Only a pending value that is not being taken this cycle
                // is actually lost.
                if (vga_valid && !vga_ready) begin
                    overflow <= 1'b1;
                end
            end else if (handshake) begin
                vga_valid <= 1'b0;
            end

            // Reads and writes are exclusive (wren), so this never races
            // with the overflow set above.
            if (rd_stat) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_button_bridge.sv
// -----------------------------------------------------------------------------
// tb_mmio_button_bridge
//
// Directed bench for mmio_button_bridge. Inputs change 1 time unit after a
// rising edge; outputs are checked 1 time unit after the following rising
// edge, so every check sees the state loaded at that edge.
// -----------------------------------------------------------------------------
module tb_mmio_button_bridge;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_ram;
    logic        btn_l;
    logic        btn_r;
    logic        btn_u;
    logic        btn_d;
    logic [31:0] q_dmem;
    logic [31:0] vga_data;
    logic        vga_valid;
    logic        vga_ready;

    int errors = 0;
    int checks = 0;

    // Values expected to leave on the VGA handshake, oldest first.
    logic [31:0] exp_q[$];

    localparam logic [31:0] A_OUT  = 32'd2000;
    localparam logic [31:0] A_STAT = 32'd2004;
    localparam logic [31:0] A_BTNL = 32'd3000;
    localparam logic [31:0] A_BTNR = 32'd4000;
    localparam logic [31:0] A_BTNU = 32'd5000;
    localparam logic [31:0] A_IDLE = 32'd100;

    mmio_button_bridge dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .q_ram        (q_ram),
        .btn_l        (btn_l),
        .btn_r        (btn_r),
        .btn_u        (btn_u),
        .btn_d        (btn_d),
        .q_dmem       (q_dmem),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .vga_ready    (vga_ready)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wren         = 1'b0;
        address_dmem = A_IDLE;
        data         = 32'h0;
    endtask

    task automatic drive_read(input logic [31:0] addr);
        wren         = 1'b0;
        address_dmem = addr;
        data         = 32'h0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] wdata);
        wren         = 1'b1;
        address_dmem = addr;
        data         = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL reset_q_dmem: got %h expected %h", q_dmem, 32'h0);
        end
        checks++;
        if (vga_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_vga_valid: got %b expected 0", vga_valid);
        end
        checks++;
        if (vga_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_vga_data: got %h expected %h", vga_data, 32'h0);
        end
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", q_dmem, 32'h0);
        end
        drive_idle();
    endtask

    task automatic test_ram_read();
        q_ram = 32'hDEADBEEF;
        drive_read(A_IDLE);
        cyc();
        checks++;
        if (q_dmem !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ram_read: got %h expected %h", q_dmem, 32'hDEADBEEF);
        end
        // A write elsewhere must leave the bridge alone; q_dmem still follows q_ram.
        q_ram = 32'h1234_5678;
        drive_write(A_IDLE, 32'hFFFF_FFFF);
        cyc();
        checks++;
        if (vga_valid !== 1'b0 || vga_data !== 32'h0) begin
            errors++;
            $display("FAIL write_elsewhere: got valid=%b data=%h expected valid=0 data=0",
                     vga_valid, vga_data);
        end
        checks++;
        if (q_dmem !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ram_passthrough: got %h expected %h", q_dmem, 32'h1234_5678);
        end
        q_ram = 32'h0;
        drive_idle();
        cyc();
    endtask

    task automatic test_btn_l_event();
        btn_l = 1'b1;
        cyc();                    // sync1 loads
        cyc();                    // sync2 loads
        btn_l = 1'b0;
        cyc();                    // flag sets
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h4) begin
            errors++;
            $display("FAIL btn_l_status: got %h expected %h", q_dmem, 32'h4);
        end
        drive_read(A_BTNL);
        cyc();
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL btn_l_first_read: got %h expected %h", q_dmem, 32'h1);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL btn_l_second_read: got %h expected %h", q_dmem, 32'h0);
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_btn_u_collision();
        btn_u = 1'b1;
        cyc();
        cyc();
        drive_read(A_BTNU);       // read lands on the flag-set edge
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL btn_u_collide_read: got %h expected %h", q_dmem, 32'h0);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL btn_u_after_collide: got %h expected %h", q_dmem, 32'h1);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL btn_u_cleared: got %h expected %h", q_dmem, 32'h0);
        end
        btn_u = 1'b0;
        drive_idle();
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_btn_held_through_reset();
        btn_r = 1'b1;
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();                    // 1st edge after reset: sync1
        cyc();                    // 2nd edge: sync2
        drive_read(A_BTNR);
        cyc();                    // 3rd edge: flag sets, read sees old value
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL btn_r_reset_early: got %h expected %h", q_dmem, 32'h0);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL btn_r_reset_event: got %h expected %h", q_dmem, 32'h1);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL btn_r_single_event: got %h expected %h", q_dmem, 32'h0);
        end
        btn_r = 1'b0;
        drive_idle();
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_vga_hold();
        vga_ready = 1'b0;
        drive_write(A_OUT, 32'h0000_00AB);
        exp_q.push_back(32'h0000_00AB);
        cyc();
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (vga_valid !== 1'b1 || vga_data !== 32'hAB) begin
                errors++;
                $display("FAIL vga_hold[%0d]: got valid=%b data=%h expected valid=1 data=ab",
                         i, vga_valid, vga_data);
            end
            cyc();
        end
        checks++;
        if (vga_data !== exp_q[0]) begin
            errors++;
            $display("FAIL vga_handshake_data: got %h expected %h", vga_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        vga_ready = 1'b1;
        cyc();
        vga_ready = 1'b0;
        checks++;
        if (vga_valid !== 1'b0) begin
            errors++;
            $display("FAIL vga_consumed: got %b expected 0", vga_valid);
        end
    endtask

    task automatic test_overflow();
        vga_ready = 1'b0;
        drive_write(A_OUT, 32'h11);
        cyc();
        drive_write(A_OUT, 32'h22);
        cyc();
        checks++;
        if (vga_data !== 32'h22) begin
            errors++;
            $display("FAIL overflow_data: got %h expected %h", vga_data, 32'h22);
        end
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h3) begin
            errors++;
            $display("FAIL overflow_status1: got %h expected %h", q_dmem, 32'h3);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL overflow_status2: got %h expected %h", q_dmem, 32'h1);
        end
        drive_idle();
        vga_ready = 1'b1;
        cyc();
        vga_ready = 1'b0;
        checks++;
        if (vga_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: got %b expected 0", vga_valid);
        end
    endtask

    task automatic test_back_to_back();
        vga_ready = 1'b0;
        drive_write(A_OUT, 32'h30);
        cyc();
        vga_ready = 1'b1;
        drive_write(A_OUT, 32'h33);
        cyc();
        vga_ready = 1'b0;
        checks++;
        if (vga_valid !== 1'b1 || vga_data !== 32'h33) begin
            errors++;
            $display("FAIL b2b_data: got valid=%b data=%h expected valid=1 data=33",
                     vga_valid, vga_data);
        end
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h1) begin
            errors++;
            $display("FAIL b2b_no_overflow: got %h expected %h", q_dmem, 32'h1);
        end
        drive_idle();
        vga_ready = 1'b1;
        cyc();
        vga_ready = 1'b0;
    endtask

    task automatic test_ignored_writes();
        drive_write(A_STAT, 32'hFFFF_FFFF);
        cyc();
        drive_write(A_BTNL, 32'h1);
        cyc();
        checks++;
        if (vga_valid !== 1'b0 || vga_data !== 32'h33) begin
            errors++;
            $display("FAIL ignored_write_vga: got valid=%b data=%h expected valid=0 data=33",
                     vga_valid, vga_data);
        end
        drive_read(A_BTNL);
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL ignored_write_btn: got %h expected %h", q_dmem, 32'h0);
        end
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL ignored_write_status: got %h expected %h", q_dmem, 32'h0);
        end
        drive_idle();
    endtask

    task automatic test_reset_all_flags();
        btn_l = 1'b1;
        btn_r = 1'b1;
        btn_u = 1'b1;
        btn_d = 1'b1;
        cyc();
        cyc();
        cyc();
        btn_l = 1'b0;
        btn_r = 1'b0;
        btn_u = 1'b0;
        btn_d = 1'b0;
        vga_ready = 1'b0;
        drive_write(A_OUT, 32'h44);
        cyc();
        drive_write(A_OUT, 32'h55);
        cyc();
        drive_read(A_STAT);
        cyc();
        checks++;
        if (q_dmem !== 32'h3F) begin
            errors++;
            $display("FAIL all_flags_status: got %h expected %h", q_dmem, 32'h3F);
        end
        // Status read with everything set, but reset must win.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (q_dmem !== 32'h0 || vga_valid !== 1'b0 || vga_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h valid=%b data=%h expected all 0",
                     q_dmem, vga_valid, vga_data);
        end
        cyc();
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags_cleared: got %h expected %h", q_dmem, 32'h0);
        end
        drive_idle();
        cyc();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset     = 1'b1;
        wren      = 1'b0;
        address_dmem = A_IDLE;
        data      = 32'h0;
        q_ram     = 32'h0;
        btn_l     = 1'b0;
        btn_r     = 1'b0;
        btn_u     = 1'b0;
        btn_d     = 1'b0;
        vga_ready = 1'b0;

        test_reset();
        test_ram_read();
        test_btn_l_event();
        test_btn_u_collision();
        test_btn_held_through_reset();
        test_vga_hold();
        test_overflow();
        test_back_to_back();
        test_ignored_writes();
        test_reset_all_flags();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
